// File: rtl/sobel_sched_pkg.sv
// Shared types for the Sobel row scheduler: FSM states, line-feed selects, word-counter sizing.
// No logic; no latency; no backpressure.
package sobel_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_FILTER = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } sched_state_t;

  typedef enum logic [1:0] {
    LINE_NONE = 2'd0,
    LINE_1    = 2'd1,
    LINE_2    = 2'd2,
    LINE_3    = 2'd3
  } line_sel_t;

  localparam int unsigned LINES_PER_ROW = 3;

  function automatic int unsigned word_cnt_w(input int unsigned words_per_line);
    return (LINES_PER_ROW * words_per_line > 2) ? $clog2(LINES_PER_ROW * words_per_line) : 1;
  endfunction

endpackage

// File: rtl/sobel_sched_word_router.sv
// Steers returned read words to line feeds 1/2/3 by position in the row; flags words with nowhere to go.
// Latency: 1 cycle from i_rd_data_valid to line valid; no backpressure, dropped words set o_ovf_err.
module sobel_sched_word_router
  import sobel_sched_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_accept,
  input  logic        i_row_release,
  input  logic        i_rd_data_valid,
  input  logic [63:0] i_rd_data,
  output logic [63:0] o_line_data,
  output logic        o_line1_data_valid,
  output logic        o_line2_data_valid,
  output logic        o_line3_data_valid,
  output logic        o_row_full,
  output logic        o_word_taken,
  output logic        o_ovf_err
);

  localparam int unsigned CW = word_cnt_w(WORDS_PER_LINE);
  localparam logic [CW-1:0] L2_FIRST = CW'(WORDS_PER_LINE);
  localparam logic [CW-1:0] L3_FIRST = CW'(2 * WORDS_PER_LINE);
  localparam logic [CW-1:0] ROW_LAST = CW'(LINES_PER_ROW * WORDS_PER_LINE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          err_q, err_d;
  logic [63:0]   data_q, data_d;
  line_sel_t     sel_q, sel_d, sel_cur;
  logic          take;

  // Once a full row has been collected, further words are overflow until the filter consumes it.
  assign take = i_rd_data_valid && i_accept && !full_q;

  always_comb begin
    if (cnt_q < L2_FIRST)      sel_cur = LINE_1;
    else if (cnt_q < L3_FIRST) sel_cur = LINE_2;
    else                       sel_cur = LINE_3;
  end

  always_comb begin
    cnt_d  = cnt_q;
    full_d = full_q;
    err_d  = err_q;
    data_d = data_q;
    sel_d  = LINE_NONE;
    if (i_row_release) full_d = 1'b0;
    if (take) begin
      data_d = i_rd_data;
      sel_d  = sel_cur;
      if (cnt_q == ROW_LAST) begin
        cnt_d  = '0;
        full_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (i_rd_data_valid) begin
      err_d = 1'b1;
    end
    if (i_clr) begin
      cnt_d  = '0;
      full_d = 1'b0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      sel_q  <= LINE_NONE;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
      err_q  <= err_d;
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

  assign o_line_data        = data_q;
  assign o_line1_data_valid = (sel_q == LINE_1);
  assign o_line2_data_valid = (sel_q == LINE_2);
  assign o_line3_data_valid = (sel_q == LINE_3);
  assign o_row_full         = full_q;
  assign o_word_taken       = take;
  assign o_ovf_err          = err_q;

endmodule

// File: rtl/sobel_row_scheduler.sv
// Frame sequencer for the 3-line Sobel datapath; optional watchdog abort under SOBEL_SCHED_WDOG_EN.
// Latency: last load word to o_filter 2 cycles; read requests held until i_rd_ack, drain waits on snooped valid&ack.
module sobel_row_scheduler
  import sobel_sched_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE     = 64,
  parameter int unsigned OUT_WORDS_PER_LINE = 64,
  parameter int unsigned ADDR_W             = 32,
  parameter int unsigned WDOG_CYCLES        = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [15:0]       i_num_rows,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [15:0]       o_rd_len,
  input  logic              i_rd_ack,
  input  logic              i_rd_data_valid,
  input  logic [63:0]       i_rd_data,
  output logic [63:0]       o_line_data,
  output logic              o_line1_data_valid,
  output logic              o_line2_data_valid,
  output logic              o_line3_data_valid,
  output logic              o_filter,
  input  logic              i_sobel_data_valid,
  input  logic              i_sobel_data_ack,
  output logic              o_busy,
  output logic [15:0]       o_row_cnt,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(WORDS_PER_LINE * 8);
  localparam logic [15:0]       OUT_LAST   = 16'(OUT_WORDS_PER_LINE - 1);

  sched_state_t      state_q, state_d, state_nxt;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       num_rows_q, num_rows_d;
  logic [15:0]       row_q, row_d;
  logic [15:0]       row_cnt_q, row_cnt_d;
  logic [15:0]       out_cnt_q, out_cnt_d;
  logic [1:0]        line_idx_q, line_idx_d;
  logic              start_acc, req_hs, out_hs, last_out, last_row;
  logic              row_full, word_taken, ovf_err, wdog_trip;

  assign start_acc = (state_q == ST_IDLE) && i_start;
  assign req_hs    = (state_q == ST_REQ) && i_rd_ack;
  assign out_hs    = (state_q == ST_DRAIN) && i_sobel_data_valid && i_sobel_data_ack;
  assign last_out  = (out_cnt_q == OUT_LAST);
  // Output row r needs source rows r..r+2, so the frame ends once row reaches num_rows-2.
  assign last_row  = ((row_q + 16'd1) == (num_rows_q - 16'd2));

  sobel_sched_word_router #(
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_router (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_clr              (start_acc),
    .i_accept           ((state_q == ST_REQ) || (state_q == ST_LOAD)),
    .i_row_release      (state_q == ST_FILTER),
    .i_rd_data_valid    (i_rd_data_valid),
    .i_rd_data          (i_rd_data),
    .o_line_data        (o_line_data),
    .o_line1_data_valid (o_line1_data_valid),
    .o_line2_data_valid (o_line2_data_valid),
    .o_line3_data_valid (o_line3_data_valid),
    .o_row_full         (row_full),
    .o_word_taken       (word_taken),
    .o_ovf_err          (ovf_err)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (i_start) state_nxt = (i_num_rows < 16'd3) ? ST_DONE : ST_REQ;
      ST_REQ:    if (req_hs && (line_idx_q == 2'd2)) state_nxt = ST_LOAD;
      ST_LOAD:   if (row_full) state_nxt = ST_FILTER;
      ST_FILTER: state_nxt = ST_DRAIN;
      ST_DRAIN:  if (out_hs && last_out) state_nxt = last_row ? ST_DONE : ST_REQ;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    state_d = wdog_trip ? ST_DONE : state_nxt;
  end

  always_comb begin
    o_rd_req = (state_q == ST_REQ);
    o_filter = (state_q == ST_FILTER);
    o_done   = (state_q == ST_DONE);
    o_busy   = (state_q != ST_IDLE);
  end

  always_comb begin
    base_d     = base_q;
    num_rows_d = num_rows_q;
    row_d      = row_q;
    row_cnt_d  = row_cnt_q;
    out_cnt_d  = out_cnt_q;
    line_idx_d = line_idx_q;
    if (start_acc) begin
      base_d     = i_base_addr;
      num_rows_d = i_num_rows;
      row_d      = '0;
      row_cnt_d  = '0;
      line_idx_d = '0;
    end
    if (req_hs) line_idx_d = (line_idx_q == 2'd2) ? 2'd0 : line_idx_q + 2'd1;
    if (state_q == ST_FILTER) out_cnt_d = '0;
    if (out_hs) begin
      out_cnt_d = out_cnt_q + 16'd1;
      if (last_out) begin
        row_d     = row_q + 16'd1;
        row_cnt_d = row_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      base_q     <= '0;
      num_rows_q <= '0;
      row_q      <= '0;
      row_cnt_q  <= '0;
      out_cnt_q  <= '0;
      line_idx_q <= '0;
    end else begin
      base_q     <= base_d;
      num_rows_q <= num_rows_d;
      row_q      <= row_d;
      row_cnt_q  <= row_cnt_d;
      out_cnt_q  <= out_cnt_d;
      line_idx_q <= line_idx_d;
    end
  end

  assign o_rd_addr = base_q + (ADDR_W'(row_q) + ADDR_W'(line_idx_q)) * LINE_BYTES;
  assign o_rd_len  = 16'(WORDS_PER_LINE);
  assign o_row_cnt = row_cnt_q;

`ifdef SOBEL_SCHED_WDOG_EN
  localparam int unsigned    WDW       = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);

  logic [WDW-1:0] wdog_q, wdog_d;
  logic           wdog_err_q, wdog_err_d;
  logic           wdog_counting, wdog_event;

  assign wdog_counting = (state_q == ST_REQ) || (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign wdog_event    = word_taken || out_hs || (state_nxt != state_q);
  assign wdog_trip     = wdog_counting && !wdog_event && (wdog_q == WDOG_LAST);

  always_comb begin
    wdog_err_d = wdog_err_q;
    if (wdog_event || !wdog_counting) wdog_d = '0;
    else                              wdog_d = wdog_q + WDW'(1);
    if (wdog_trip) wdog_err_d = 1'b1;
    if (start_acc) wdog_err_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign o_err = ovf_err || wdog_err_q;
`else
  localparam int unsigned unused_wdog_cycles = WDOG_CYCLES;
  assign wdog_trip = 1'b0;
  assign o_err     = ovf_err;
`endif

endmodule

// File: tb/tb_sobel_row_scheduler.sv
// Randomised frame bench for sobel_row_scheduler with a host/consumer model and scoreboards.
`timescale 1ns/1ps
module tb_sobel_row_scheduler;

  localparam int          W    = 4;
  localparam int          OW   = 4;
  localparam int          AW   = 32;
  localparam int          WD   = 16;
  localparam logic [31:0] BASE = 32'h1000;

  typedef struct packed { logic [31:0] addr; logic [1:0] line; } req_t;
  typedef struct packed { logic [1:0] line; logic [63:0] data; } word_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [15:0]   i_num_rows = '0;
  logic          o_rd_req;
  logic [AW-1:0] o_rd_addr;
  logic [15:0]   o_rd_len;
  logic          i_rd_ack = 1'b0;
  logic          i_rd_data_valid = 1'b0;
  logic [63:0]   i_rd_data = '0;
  logic [63:0]   o_line_data;
  logic          o_line1_data_valid, o_line2_data_valid, o_line3_data_valid;
  logic          o_filter;
  logic          i_sobel_data_valid = 1'b0;
  logic          i_sobel_data_ack = 1'b0;
  logic          o_busy;
  logic [15:0]   o_row_cnt;
  logic          o_done;
  logic          o_err;

  sobel_row_scheduler #(
    .WORDS_PER_LINE     (W),
    .OUT_WORDS_PER_LINE (OW),
    .ADDR_W             (AW),
    .WDOG_CYCLES        (WD)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_start            (i_start),
    .i_base_addr        (i_base_addr),
    .i_num_rows         (i_num_rows),
    .o_rd_req           (o_rd_req),
    .o_rd_addr          (o_rd_addr),
    .o_rd_len           (o_rd_len),
    .i_rd_ack           (i_rd_ack),
    .i_rd_data_valid    (i_rd_data_valid),
    .i_rd_data          (i_rd_data),
    .o_line_data        (o_line_data),
    .o_line1_data_valid (o_line1_data_valid),
    .o_line2_data_valid (o_line2_data_valid),
    .o_line3_data_valid (o_line3_data_valid),
    .o_filter           (o_filter),
    .i_sobel_data_valid (i_sobel_data_valid),
    .i_sobel_data_ack   (i_sobel_data_ack),
    .o_busy             (o_busy),
    .o_row_cnt          (o_row_cnt),
    .o_done             (o_done),
    .o_err              (o_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  req_t  exp_req_q[$];
  word_t exp_word_q[$];
  int    pend_line_q[$];

  int ack_delay = 0, gap_pct = 0, drain_left = 0;
  bit inject_extra = 0, hold_sobel_ack = 0;
  int filter_cnt = 0, done_cnt = 0, done_cyc = 0, filter_cyc = 0;
  int lines_seen = 0, req_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic flag_fail(input string name, input int act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d required=none", name, act);
  endtask

  // Monitor: pops scoreboards whenever the DUT presents a request handshake or a line word.
  initial begin : monitor
    logic [31:0] prev_addr;
    bit          prev_pending;
    prev_addr    = '0;
    prev_pending = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        prev_pending = 0;
      end else begin
        if (o_rd_req) begin
          if (prev_pending) check("rd_addr_hold", o_rd_addr, prev_addr);
          check("rd_len", o_rd_len, W);
          if (i_rd_ack) begin
            req_seen++;
            prev_pending = 0;
            if (exp_req_q.size() == 0) begin
              flag_fail("rd_req_unexpected", int'(o_rd_addr));
            end else begin
              req_t r;
              r = exp_req_q.pop_front();
              check("rd_addr", o_rd_addr, r.addr);
              for (int i = 0; i < W; i++) pend_line_q.push_back(int'(r.line));
            end
          end else begin
            prev_pending = 1;
            prev_addr    = o_rd_addr;
          end
        end else begin
          prev_pending = 0;
        end

        begin
          int nv, ln;
          nv = int'(o_line1_data_valid) + int'(o_line2_data_valid) + int'(o_line3_data_valid);
          ln = o_line1_data_valid ? 1 : (o_line2_data_valid ? 2 : 3);
          if (nv > 1) begin
            flag_fail("line_valid_onehot", nv);
          end else if (nv == 1) begin
            lines_seen++;
            if (exp_word_q.size() == 0) begin
              flag_fail("line_valid_unexpected", ln);
            end else begin
              word_t w;
              w = exp_word_q.pop_front();
              check("line_select", ln, w.line);
              check("line_data", o_line_data, w.data);
            end
          end
        end

        if (o_filter) begin
          filter_cnt++;
          filter_cyc = cyc;
          drain_left = OW;
        end
        if (o_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (i_sobel_data_valid && i_sobel_data_ack && drain_left > 0) drain_left--;
      end
    end
  end

  // Host request acceptor: each request is acknowledged after ack_delay waiting cycles.
  initial begin : ack_drv
    int wait_c;
    wait_c = 0;
    forever begin
      @(posedge i_clk); #1;
      if (o_rd_req && i_rst) begin
        if (wait_c >= ack_delay) begin
          i_rd_ack = 1'b1;
          wait_c   = 0;
        end else begin
          i_rd_ack = 1'b0;
          wait_c++;
        end
      end else begin
        i_rd_ack = 1'b0;
        wait_c   = 0;
      end
    end
  end

  // Host data return: words of each accepted request go to that request's line feed, in order.
  initial begin : data_drv
    forever begin
      @(posedge i_clk); #1;
      i_rd_data_valid = 1'b0;
      if (!i_rst) begin
        pend_line_q.delete();
      end else if (pend_line_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        word_t w;
        i_rd_data       = {$urandom(), $urandom()};
        i_rd_data_valid = 1'b1;
        w.line = 2'(pend_line_q.pop_front());
        w.data = i_rd_data;
        exp_word_q.push_back(w);
      end else if (inject_extra && drain_left > 0 && pend_line_q.size() == 0) begin
        i_rd_data       = {$urandom(), $urandom()};
        i_rd_data_valid = 1'b1;
        inject_extra    = 0;
      end
    end
  end

  // Downstream consumer: random valid/ack while the bench expects filtered words.
  initial begin : sink_drv
    forever begin
      @(posedge i_clk); #1;
      if (drain_left > 0 && i_rst) begin
        i_sobel_data_valid = ($urandom_range(3) != 0);
        i_sobel_data_ack   = hold_sobel_ack ? 1'b0 : ($urandom_range(3) != 0);
      end else begin
        i_sobel_data_valid = 1'b0;
        i_sobel_data_ack   = 1'b0;
      end
    end
  end

  task automatic start_frame(input logic [31:0] base, input int nr, input int ackd, input int gap);
    ack_delay  = ackd;
    gap_pct    = gap;
    filter_cnt = 0;
    done_cnt   = 0;
    lines_seen = 0;
    req_seen   = 0;
    for (int r = 0; r <= nr - 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        req_t q;
        q.addr = base + 32'((r + k) * W * 8);
        q.line = 2'(k + 1);
        exp_req_q.push_back(q);
      end
    end
    @(posedge i_clk); #1;
    i_base_addr = base;
    i_num_rows  = 16'(nr);
    i_start     = 1'b1;
    @(posedge i_clk); #1;
    i_start     = 1'b0;
    i_base_addr = $urandom();
    i_num_rows  = 16'($urandom());
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 4000 && done_cnt == 0; i++) @(negedge i_clk);
    if (done_cnt == 0) flag_fail({tag, "_done_timeout"}, i);
    repeat (4) @(negedge i_clk);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] base, input int nr,
                           input int ackd, input int gap, input bit extra);
    int rows, s_cyc;
    rows = (nr >= 3) ? nr - 2 : 0;
    start_frame(base, nr, ackd, gap);
    s_cyc = cyc - 1;
    inject_extra = extra;
    @(negedge i_clk);
    check({tag, "_busy"}, o_busy, 1);
    wait_done(tag);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_filter_pulses"}, filter_cnt, rows);
    check({tag, "_row_cnt"}, o_row_cnt, rows);
    check({tag, "_requests"}, req_seen, 3 * rows);
    check({tag, "_words"}, lines_seen, 3 * W * rows);
    check({tag, "_busy_after"}, o_busy, 0);
    check({tag, "_err"}, o_err, extra);
    check({tag, "_req_left"}, exp_req_q.size(), 0);
    check({tag, "_word_left"}, exp_word_q.size(), 0);
    if (nr < 3) check_range({tag, "_done_latency"}, done_cyc - s_cyc, 1, 2);
    inject_extra = 0;
  endtask

  initial begin : main
    #12;
    check("rst_busy", o_busy, 0);
    check("rst_rd_req", o_rd_req, 0);
    check("rst_rd_addr", o_rd_addr, 0);
    check("rst_filter", o_filter, 0);
    check("rst_done", o_done, 0);
    check("rst_row_cnt", o_row_cnt, 0);
    check("rst_err", o_err, 0);
    check("rst_line_valids", {o_line1_data_valid, o_line2_data_valid, o_line3_data_valid}, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;

    run_frame("zero_wait", BASE, 4, 0, 0, 0);
    run_frame("short2", BASE, 2, 0, 0, 0);
    run_frame("short0", BASE, 0, 0, 0, 0);
    run_frame("slow_ack", BASE, 3, 5, 0, 0);
    run_frame("extra_word", BASE, 4, 1, 30, 1);
    run_frame("addr_wrap", 32'hFFFF_FFC0, 4, 2, 20, 0);

    // Reset in the middle of loading a row, then a clean frame.
    begin
      int i;
      start_frame(BASE, 5, 0, 0);
      for (i = 0; i < 500 && lines_seen < 5; i++) @(negedge i_clk);
      if (lines_seen < 5) flag_fail("midload_timeout", lines_seen);
      @(posedge i_clk); #3;
      i_rst = 1'b0;
      #1;
      check("midrst_busy", o_busy, 0);
      check("midrst_rd_req", o_rd_req, 0);
      check("midrst_filter", o_filter, 0);
      check("midrst_done", o_done, 0);
      check("midrst_row_cnt", o_row_cnt, 0);
      check("midrst_err", o_err, 0);
      check("midrst_line_data", o_line_data, 0);
      check("midrst_line_valids", {o_line1_data_valid, o_line2_data_valid, o_line3_data_valid}, 0);
      exp_req_q.delete();
      exp_word_q.delete();
      pend_line_q.delete();
      drain_left = 0;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      run_frame("post_rst", BASE, 3, 1, 10, 0);
    end

    for (int f = 0; f < 4; f++) begin
      run_frame("random", BASE + 32'($urandom_range(255) * 8), 3 + int'($urandom_range(3)),
                int'($urandom_range(3)), int'($urandom_range(50)), 0);
    end

`ifdef SOBEL_SCHED_WDOG_EN
    // Consumer never acknowledges: the watchdog must abort the frame.
    begin
      hold_sobel_ack = 1;
      start_frame(BASE, 3, 0, 0);
      wait_done("wdog");
      check("wdog_done_once", done_cnt, 1);
      check("wdog_filter_pulses", filter_cnt, 1);
      check_range("wdog_done_delay", done_cyc - filter_cyc, 16, 18);
      check("wdog_err", o_err, 1);
      check("wdog_row_cnt", o_row_cnt, 0);
      check("wdog_busy_after", o_busy, 0);
      hold_sobel_ack = 0;
      drain_left     = 0;
      run_frame("after_wdog", BASE, 3, 0, 0, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : global_timeout
    #800000;
    $display("FAIL global_timeout actual=%0d cycles required=finish", cyc);
    $fatal(1);
  end

endmodule
